// File: rtl/periph_bus_ctrl.sv
// rtl/periph_bus_ctrl.sv - Peripheral bus controller: address decode, one-at-a-time slave handshake,
// timeout and error reporting back to the core's uncached data port.
package periph_bus_pkg;
  typedef enum logic [2:0] {
    STORE_NONE  = 3'd0,
    STORE_BYTE  = 3'd1,
    STORE_HALF  = 3'd2,
    STORE_WORD  = 3'd3,
    STORE_DWORD = 3'd4
  } mem_store_type_t;
endpackage

module periph_bus_ctrl
  import periph_bus_pkg::*;
#(
  parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
  parameter int          N_SLAVES        = 4,
  parameter logic [63:0] SLAVE_SPAN      = 64'h1000,
  parameter int          TIMEOUT         = 255,
  localparam int         AW              = $clog2(SLAVE_SPAN)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [63:0]              d_addr,
  input  logic [63:0]              d_wdata,
  input  mem_store_type_t          d_store_type,
  input  logic                     d_valid,
  output logic [63:0]              d_rdata,
  output logic                     d_ready,
  output logic [N_SLAVES-1:0]      s_valid,
  output logic [AW-1:0]            s_addr,
  output logic [63:0]              s_wdata,
  output mem_store_type_t          s_store_type,
  input  logic [N_SLAVES-1:0]      s_ready,
  input  logic [N_SLAVES*64-1:0]   s_rdata,
  output logic                     bus_err,
  output logic [63:0]              err_addr,
  output logic [7:0]               err_count
);

  localparam int          IW       = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [63:0] WINDOW   = 64'(N_SLAVES) * SLAVE_SPAN;
  localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [63:0]     r_addr;
  logic [63:0]     r_wdata;
  logic [63:0]     r_rdata;
  logic [63:0]     r_err_addr;
  logic [AW-1:0]   r_off;
  logic [IW-1:0]   r_idx;
  mem_store_type_t r_store_type;
  logic            r_err;
  logic [15:0]     r_cnt;
  logic [7:0]      r_err_count;

  logic [63:0]     w_off;
  logic            w_in_range;
  logic [16:0]     w_cnt_inc;
  logic            w_sel_ready;
  logic            w_timeout;

  // Unsigned wrap of the subtraction is harmless: the >= BASE term rejects it.
  assign w_off       = d_addr - PERIPHERAL_BASE;
  assign w_in_range  = (d_addr >= PERIPHERAL_BASE) && (w_off < WINDOW);
  assign w_cnt_inc   = {1'b0, r_cnt} + 17'd1;
  assign w_sel_ready = s_ready[r_idx];
  assign w_timeout   = (w_cnt_inc == TO_LIMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (d_valid) w_state_next = w_in_range ? ISSUE : RESP;
      ISSUE:   if (w_sel_ready || w_timeout) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err_addr   <= '0;
      r_off        <= '0;
      r_idx        <= '0;
      r_store_type <= STORE_NONE;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_err_count  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (d_valid) begin
            r_addr <= d_addr;
            r_err  <= !w_in_range;
            r_cnt  <= '0;
            if (w_in_range) begin
              r_idx        <= w_off[AW +: IW];
              r_off        <= w_off[AW-1:0];
              r_wdata      <= d_wdata;
              r_store_type <= d_store_type;
            end else begin
              r_rdata <= '1;
            end
          end
        end
        ISSUE: begin
          // A ready arriving in the final counted cycle still beats the timeout.
          if (w_sel_ready) begin
            r_rdata <= s_rdata[{r_idx, 6'd0} +: 64];
          end else if (w_timeout) begin
            r_rdata <= '1;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc[15:0];
          end
        end
        RESP: begin
          if (r_err) begin
            r_err_addr <= r_addr;
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_valid      = (r_state == ISSUE) ? (N_SLAVES'(1) << r_idx) : '0;
  assign s_addr       = r_off;
  assign s_wdata      = r_wdata;
  assign s_store_type = r_store_type;
  assign d_ready      = (r_state == RESP);
  assign d_rdata      = r_rdata;
  assign bus_err      = (r_state == RESP) && r_err;
  assign err_addr     = r_err_addr;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// tb/tb_periph_bus_ctrl.sv - Directed and randomized check of periph_bus_ctrl against a
// transaction-timeline model (acceptance cycle, issue window, completion cycle).
`timescale 1ns/1ps
module tb_periph_bus_ctrl;
  import periph_bus_pkg::*;

  localparam logic [63:0] BASE = 64'h2000_0000;
  localparam int          NS   = 4;
  localparam logic [63:0] SPAN = 64'h1000;
  localparam int          TO   = 8;
  localparam int          AW   = 12;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [63:0]       d_addr = '0;
  logic [63:0]       d_wdata = '0;
  mem_store_type_t   d_store_type = STORE_NONE;
  logic              d_valid = 1'b0;
  logic [63:0]       d_rdata;
  logic              d_ready;
  logic [NS-1:0]     s_valid;
  logic [AW-1:0]     s_addr;
  logic [63:0]       s_wdata;
  mem_store_type_t   s_store_type;
  logic [NS-1:0]     s_ready = '0;
  logic [NS*64-1:0]  s_rdata = '0;
  logic              bus_err;
  logic [63:0]       err_addr;
  logic [7:0]        err_count;

  periph_bus_ctrl #(
    .PERIPHERAL_BASE(BASE), .N_SLAVES(NS), .SLAVE_SPAN(SPAN), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_store_type(d_store_type), .d_valid(d_valid),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_store_type(s_store_type),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .bus_err(bus_err), .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0]     addr;
    logic [63:0]     wdata;
    mem_store_type_t st;
    int              dly;
    logic [63:0]     rd;
    logic [NS-1:0]   spur;
  } req_t;

  req_t q[$];
  bit   hold = 1'b0;

  // Transaction currently modelled: accepted in cycle t_a, completes in cycle t_done.
  bit              t_act = 1'b0;
  int              t_a = 0, t_done = 0, t_idx = 0, t_dly = 0;
  bit              t_inr = 1'b0, t_err = 1'b0;
  logic [63:0]     t_off = '0, t_addr = '0, t_wdata = '0, t_rdata = '0, t_rd = '0;
  mem_store_type_t t_st = STORE_NONE;
  logic [NS-1:0]   t_spur = '0;
  logic [63:0]     m_err_addr = '0;
  int              m_err_count = 0;

  int              obs_lat = 0, obs_sv_cycles = 0;
  logic [NS-1:0]   obs_sv = '0;
  logic [63:0]     obs_rdata = '0, obs_swdata = '0;
  logic            obs_err = 1'b0;
  logic [AW-1:0]   obs_saddr = '0;
  mem_store_type_t obs_sst = STORE_NONE;
  int              dr_cycles[$];

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  int            cmp_c;
  bit            cmp_issue, cmp_resp;
  logic [NS-1:0] cmp_sv;

  always @(negedge clock) begin
    if (reset) begin
      cmp_c     = cyc;
      cmp_issue = t_act && t_inr && (cmp_c > t_a) && (cmp_c < t_done);
      cmp_resp  = t_act && (cmp_c == t_done);
      cmp_sv    = cmp_issue ? (NS'(1) << t_idx) : '0;
      if (t_act && cmp_c == t_a) begin
        obs_sv = '0;
        obs_sv_cycles = 0;
      end
      check("s_valid", s_valid, cmp_sv);
      if (cmp_issue) begin
        check("s_addr", s_addr, t_off[AW-1:0]);
        check("s_wdata", s_wdata, t_wdata);
        check("s_store_type", s_store_type, t_st);
        obs_sv     = obs_sv | s_valid;
        obs_sv_cycles++;
        obs_saddr  = s_addr;
        obs_swdata = s_wdata;
        obs_sst    = s_store_type;
      end
      check("d_ready", d_ready, cmp_resp);
      check("bus_err", bus_err, cmp_resp && t_err);
      if (cmp_resp) begin
        check("d_rdata", d_rdata, t_rdata);
        obs_lat   = cmp_c - t_a;
        obs_rdata = d_rdata;
        obs_err   = bus_err;
        dr_cycles.push_back(cmp_c);
      end
      check("err_addr", err_addr, m_err_addr);
      check("err_count", err_count, 64'(m_err_count));
      if (cmp_resp && t_err) begin
        m_err_addr = t_addr;
        if (m_err_count < 255) m_err_count++;
      end
    end
  end

  task automatic accept(req_t r, int c);
    logic [63:0] off;
    d_valid = 1'b1; d_addr = r.addr; d_wdata = r.wdata; d_store_type = r.st;
    off    = r.addr - BASE;
    t_act  = 1'b1; t_a = c; t_addr = r.addr; t_wdata = r.wdata; t_st = r.st;
    t_dly  = r.dly; t_rd = r.rd; t_spur = r.spur;
    t_inr  = (r.addr >= BASE) && (off < 64'(NS) * SPAN);
    if (!t_inr) begin
      t_err = 1'b1; t_rdata = ONES; t_done = c + 1;
    end else begin
      t_idx = int'(off / SPAN);
      t_off = off % SPAN;
      if (r.dly > TO) begin
        t_err = 1'b1; t_rdata = ONES; t_done = c + TO + 1;
      end else begin
        t_err = 1'b0; t_rdata = r.rd; t_done = c + r.dly + 1;
      end
    end
  endtask

  task automatic step();
    int   c;
    bit   free;
    req_t r;
    @(posedge clock); #2;
    c = cyc;
    free = !t_act || (c > t_done);
    s_ready = NS'($urandom);
    for (int k = 0; k < NS; k++) s_rdata[k*64 +: 64] = {$urandom, $urandom};
    if (free) begin
      if (q.size() > 0 && (hold || $urandom_range(0, 3) != 0)) begin
        r = q.pop_front();
        accept(r, c);
      end else begin
        d_valid = 1'b0;
        d_addr  = {$urandom, $urandom};
      end
    end else begin
      d_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
      d_addr  = {$urandom, $urandom};
      d_wdata = {$urandom, $urandom};
      if (t_inr && c > t_a && c < t_done) begin
        s_ready = (NS'($urandom) | t_spur) & ~(NS'(1) << t_idx);
        if (c == t_a + t_dly) begin
          s_ready[t_idx] = 1'b1;
          s_rdata[t_idx*64 +: 64] = t_rd;
        end
      end
    end
  endtask

  task automatic run_q();
    int budget = 20000;
    while ((q.size() > 0 || (t_act && cyc <= t_done)) && budget > 0) begin
      step();
      budget--;
    end
    check("run_budget", 64'(budget > 0), 1);
  endtask

  task automatic add_req(logic [63:0] addr, logic [63:0] wdata, mem_store_type_t st,
                         int dly, logic [63:0] rd, logic [NS-1:0] spur);
    req_t r;
    r.addr = addr; r.wdata = wdata; r.st = st; r.dly = dly; r.rd = rd; r.spur = spur;
    q.push_back(r);
  endtask

  task automatic add_random();
    logic [63:0] a;
    case ($urandom_range(0, 5))
      0, 1, 2: a = BASE + 64'($urandom_range(0, NS*4096 - 1));
      3:       a = BASE + 64'(NS) * SPAN + 64'($urandom_range(0, 64));
      4:       a = BASE - 64'(1) - 64'($urandom_range(0, 64));
      default: a = {$urandom, $urandom};
    endcase
    add_req(a, {$urandom, $urandom}, mem_store_type_t'(3'($urandom_range(0, 4))),
            $urandom_range(1, TO + 2), {$urandom, $urandom}, '0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_d_ready", d_ready, 0);
    check("rst_s_valid", s_valid, 0);
    check("rst_err_count", err_count, 0);
    #3 reset = 1'b1;

    add_req(64'h2000_1010, 64'h0, STORE_NONE, 1, 64'h1234, '0);
    run_q();
    check("load1_latency", obs_lat, 2);
    check("load1_rdata", obs_rdata, 64'h1234);
    check("load1_sv", obs_sv, 4'b0010);
    check("load1_saddr", obs_saddr, 12'h010);
    check("load1_err", obs_err, 0);

    add_req(64'h2000_3008, 64'hAB, STORE_WORD, 5, 64'h77, '0);
    run_q();
    check("store3_sv", obs_sv, 4'b1000);
    check("store3_sv_cycles", obs_sv_cycles, 5);
    check("store3_wdata", obs_swdata, 64'hAB);
    check("store3_type", obs_sst, STORE_WORD);
    check("store3_latency", obs_lat, 6);

    add_req(64'h2000_4000, 64'h0, STORE_NONE, 1, 64'h0, '0);
    run_q();
    check("unmap1_sv_cycles", obs_sv_cycles, 0);
    check("unmap1_latency", obs_lat, 1);
    check("unmap1_err", obs_err, 1);
    check("unmap1_rdata", obs_rdata, ONES);
    check("unmap1_err_addr", err_addr, 64'h2000_4000);
    add_req(64'h1FFF_FFF8, 64'h0, STORE_NONE, 1, 64'h0, '0);
    run_q();
    check("unmap2_err_addr", err_addr, 64'h1FFF_FFF8);
    check("unmap2_err_count", err_count, 2);

    add_req(64'h2000_0020, 64'h0, STORE_NONE, TO + 1, 64'h55, '0);
    run_q();
    check("tmo_sv_cycles", obs_sv_cycles, 8);
    check("tmo_latency", obs_lat, 9);
    check("tmo_err", obs_err, 1);
    check("tmo_rdata", obs_rdata, ONES);
    add_req(64'h2000_0020, 64'h0, STORE_NONE, TO, 64'hC0FFEE, '0);
    run_q();
    check("tmo_edge_err", obs_err, 0);
    check("tmo_edge_latency", obs_lat, 9);
    check("tmo_edge_rdata", obs_rdata, 64'hC0FFEE);

    add_req(64'h2000_2044, 64'h99, STORE_BYTE, 6, 64'h1, '0);
    step();
    step();
    check("rst_pre_sv", s_valid, 4'b0100);
    #1 reset = 1'b0;
    #1;
    check("arst_s_valid", s_valid, 0);
    check("arst_d_ready", d_ready, 0);
    check("arst_d_rdata", d_rdata, 0);
    check("arst_s_addr", s_addr, 0);
    check("arst_s_wdata", s_wdata, 0);
    check("arst_s_store_type", s_store_type, 0);
    check("arst_bus_err", bus_err, 0);
    check("arst_err_addr", err_addr, 0);
    check("arst_err_count", err_count, 0);
    t_act = 1'b0; m_err_addr = '0; m_err_count = 0; q.delete();
    d_valid = 1'b0;
    @(posedge clock); #3 reset = 1'b1;

    add_req(64'h2000_0100, 64'h0, STORE_NONE, 1, 64'h5A5A, '0);
    run_q();
    check("post_rst_latency", obs_lat, 2);
    check("post_rst_rdata", obs_rdata, 64'h5A5A);
    check("post_rst_sv", obs_sv, 4'b0001);

    hold = 1'b1;
    dr_cycles.delete();
    for (int i = 0; i < 4; i++)
      add_req(BASE + 64'(8*i), 64'h0, STORE_NONE, 1, 64'h100 + 64'(i), 4'b0010);
    run_q();
    hold = 1'b0;
    check("b2b_count", dr_cycles.size(), 4);
    for (int i = 1; i < dr_cycles.size(); i++)
      check("b2b_spacing", dr_cycles[i] - dr_cycles[i-1], 3);
    check("b2b_last_rdata", obs_rdata, 64'h103);

    for (int i = 0; i < 200; i++) add_random();
    run_q();
    hold = 1'b1;
    for (int i = 0; i < 200; i++) add_random();
    run_q();

    for (int i = 0; i < 260; i++)
      add_req(BASE + 64'(NS) * SPAN, 64'h0, STORE_NONE, 1, 64'h0, '0);
    run_q();
    hold = 1'b0;
    check("sat_err_count", err_count, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus_ctrl.md
# periph_bus_ctrl

Peripheral bus controller between the core's uncached data port (`d_*`) and up to `N_SLAVES` memory-mapped peripherals. It decodes the address, sequences one transaction at a time through a valid/ready handshake to the selected slave, and returns data to the core with a single-cycle `d_ready` pulse. Transactions that hit unmapped addresses or time out are answered with an error pattern, so the core's hazard stall always releases.

## Interface

Parameters:
- `PERIPHERAL_BASE`, default 64'h2000_0000: base address of the peripheral window.
- `N_SLAVES`, default 4: number of slave ports, range 1–16.
- `SLAVE_SPAN`, default 64'h1000: bytes per slave window; must be a power of two.
- `TIMEOUT`, default 255: maximum wait cycles for `s_ready`, range 1–65535.

Ports:
- `clock` in 1: the only clock.
- `reset` in 1: asynchronous, active-low.
- `d_addr` in 64: core request address.
- `d_wdata` in 64: core store data.
- `d_store_type` in `mem_store_type_t`: nonzero means store, zero means load.
- `d_valid` in 1: core request.
- `d_rdata` out 64: load data returned to the core.
- `d_ready` out 1: one-cycle completion pulse.
- `s_valid` out `N_SLAVES`: one-hot request to the selected slave.
- `s_addr` out AW: offset within the slave window, where AW = $clog2(`SLAVE_SPAN`).
- `s_wdata` out 64: latched store data.
- `s_store_type` out `mem_store_type_t`: latched store type.
- `s_ready` in `N_SLAVES`: per-slave completion.
- `s_rdata` in `N_SLAVES`*64: slave k drives bits [64k+63:64k].
- `bus_err` out 1: one-cycle pulse marking an error completion.
- `err_addr` out 64: address of the most recent error.
- `err_count` out 8: saturating error counter.

## Operation

- States: IDLE, ISSUE, RESP.
- Address decode is computed in IDLE:
  - off = `d_addr` − `PERIPHERAL_BASE`, using 64-bit unsigned arithmetic.
  - The address is in range iff `d_addr` ≥ `PERIPHERAL_BASE` and off < `N_SLAVES`*`SLAVE_SPAN`.
  - Slave index idx = off / `SLAVE_SPAN`.
  - Slave offset = off[AW-1:0].
- IDLE, `d_valid`=1, address in range:
  - Latch idx, offset, `d_wdata` and `d_store_type`.
  - Clear the timeout counter.
  - Go to ISSUE.
- IDLE, `d_valid`=1, address out of range:
  - Set rdata register to 64'hFFFF_FFFF_FFFF_FFFF.
  - Set the error flag and go to RESP.
  - No slave sees `s_valid`.
- ISSUE:
  - `s_valid`[idx]=1; `s_addr`, `s_wdata` and `s_store_type` are driven from the latched values.
  - `s_ready`[idx]=1: capture `s_rdata` slice idx into the rdata register and go to RESP. Store completions capture the slice too; the core ignores it.
  - Otherwise increment the counter. When the counter equals `TIMEOUT` without ready: rdata = all-ones, set the error flag, go to RESP.
  - `s_ready` bits of non-selected slaves are ignored.
- RESP:
  - `d_ready`=1 and `d_rdata` = rdata register.
  - If the error flag is set: `bus_err`=1, `err_addr` ← latched full address, `err_count` ← min(`err_count`+1, 255).
  - Go to IDLE unconditionally.
- `d_valid` dropping mid-transaction does not abort it; it completes normally.
- Only one transaction is outstanding at a time. A `d_valid` seen in RESP is not accepted; it is accepted in the following IDLE cycle.

## Timing

- Reset (asserted at 0, async) forces the following immediately, without waiting for a clock edge:
  - State returns to IDLE.
  - `d_ready`=0, `d_rdata`=0.
  - `s_valid`=0, `s_addr`=0, `s_wdata`=0, `s_store_type`=0.
  - `bus_err`=0, `err_addr`=0, `err_count`=0.
- Reset mid-ISSUE drops `s_valid` at once. The slave must tolerate an abandoned request.
- All outputs are registered or decoded from state and latched values. There is no combinational path from `d_*` or `s_*` inputs to outputs.
- Fastest slave access (ready in the first ISSUE cycle): `d_valid` sampled at edge 0, ISSUE in cycle 1, `d_ready` in cycle 2. Latency is 2 cycles.
- A slave that asserts ready after n ISSUE cycles gives latency n+1.
- Out-of-range access: `d_ready` arrives 1 cycle after acceptance.
- Timeout: ISSUE lasts exactly `TIMEOUT` cycles, and `d_ready` follows in the next cycle.
- `s_ready` in the same cycle the counter reaches `TIMEOUT`: ready wins, with no error.
- Back-to-back requests: minimum spacing between two `d_ready` pulses is 3 cycles (RESP → IDLE → ISSUE).
- `err_count` saturates at 255 and holds.

## Test plan

- Load from slave 1: `d_addr`=0x2000_1010, slave returns 0x1234 in the first ISSUE cycle.
  - Expect `s_valid`=4'b0010 and `s_addr`=0x010.
  - Expect `d_ready` 2 cycles after acceptance, `d_rdata`=0x1234, `bus_err`=0.
- Store to slave 3: `d_addr`=0x2000_3008, `d_wdata`=0xAB, `d_store_type`=word, slave ready delayed 5 cycles.
  - Expect `s_valid`=4'b1000 held for 5 cycles, `s_wdata`=0xAB, `s_store_type`=word.
  - Expect `d_ready` at cycle 6.
- Unmapped addresses 0x2000_4000 and 0x1FFF_FFF8.
  - Expect no `s_valid`.
  - Expect `d_ready` and `bus_err` 1 cycle later, `d_rdata`=all-ones, `err_addr` equal to each address, `err_count` reaching 2.
- Timeout with `TIMEOUT`=8 and slave 0 never ready.
  - Expect `s_valid`[0] for 8 cycles, then `d_ready`, `bus_err`, `d_rdata`=all-ones.
  - Repeat with ready in the 8th ISSUE cycle: expect no error.
- Async reset asserted mid-ISSUE on slave 2.
  - Expect `s_valid`=0 and all outputs at reset values before the next clock edge.
  - After release, a new load to slave 0 completes normally.
- Back-to-back loads with `d_valid` held high, plus a spurious `s_ready`[1] while slave 0 is selected.
  - Expect `d_ready` pulses exactly 3 cycles apart.
  - Expect the spurious ready ignored and `d_rdata` always taken from the selected slave.
